rx_peak_scheduler: RTL
======================

// Module: rx_peak_scheduler
// PURPOSE
//  Sequences read-out of the 16 receive correlator outputs after every new sample.
//  Waits for the correlator bank to settle, then scans lanes 0..15 one per clock.
//  Tracks the largest magnitude above a threshold over a window of sample slots.
//  Reports one peak event (lane, magnitude, sample index) to the ranging logic.
//  Sits between the rx correlator bank and the time-of-arrival logic.
// PARAMETERS
//  N_CORR     16   number of correlator lanes scanned (lane id width = 4)
//  CORR_W     41   signed width of each correlation result
//  SETTLE_CYC 8    clocks from inew_sample_trig until results are stable (>=1)
//  WIN_SLOTS  32   sample slots searched after the first threshold crossing (>=1)
//  IDX_W      16   width of the sample index counter (wraps)
// PORTS
//  crx_clk         in   1              clock
//  rrx_rst_n       in   1              asynchronous reset, active low
//  erx_en          in   1              enable; low = synchronous return to IDLE
//  inew_sample_trig in  1              1-clk pulse: new sample entered correlators
//  icorr_results   in   N_CORR*CORR_W  flattened signed results, lane k at [k*CORR_W +: CORR_W]
//  ithreshold      in   CORR_W-1       unsigned detection threshold, sampled at SCAN start
//  obusy           out  1              high in SETTLE/SCAN/REPORT
//  oovr            out  1              1-clk pulse: trigger arrived while busy
//  opeak_valid     out  1              1-clk pulse: peak report valid
//  opeak_lane      out  4              lane of reported peak
//  opeak_mag       out  CORR_W-1       saturated magnitude of reported peak
//  opeak_index     out  IDX_W          sample index of reported peak
// BEHAVIOUR
//  - Reset (async, rrx_rst_n=0): all outputs 0, state IDLE, sample counter 0, window cleared.
//  - States: IDLE -> SETTLE (on trig) -> SCAN (after SETTLE_CYC clks) -> REPORT or IDLE.
//  - Sample counter increments on every accepted trig (incl. overrun trig); wraps 2^IDX_W-1 -> 0.
//    Slot index = counter value before increment.
//  - SCAN: lane k compared at SCAN cycle k, 16 cycles, lanes 0..15 in order.
//  - Magnitude = |x|; most negative input (-2^(CORR_W-1)) saturates to 2^(CORR_W-1)-1.
//  - Candidate when mag > ithreshold (strict). Best replaced only if mag > best (strict):
//    ties keep lower lane and earlier slot.
//  - First candidate opens the window; WIN_SLOTS completed scans (incl. opening one) close it.
//  - Window close -> REPORT for 1 clk: opeak_valid=1, lane/mag/index of best, then window cleared.
//    Scan completing with no open window -> IDLE.
//  - opeak_lane/mag/index hold last reported value until next report or reset.
//  - Trig while obusy: oovr pulses, current slot discarded (not counted in window), restart SETTLE.
//  - Trig in REPORT cycle: report still issued, trig accepted normally (no oovr).
//  - Trig coinciding with erx_en low: ignored, counter not incremented.
//  - erx_en low: next clk IDLE, window and best cleared, counter held, no report.
//  - Latency: opeak_valid asserts SETTLE_CYC+N_CORR+1 clks after the trig of the closing slot.
//  - Reset mid-scan: immediate IDLE, no partial report.
// STRUCTURE
//  - Shared package rx_pkg: state encoding (IDLE/SETTLE/SCAN/REPORT), N_CORR, CORR_W defaults.
//  - Sub-module rx_abs_sat: combinational signed->saturated magnitude, CORR_W param.
//  - Top: FSM, settle/lane/window counters, best-peak registers, lane mux.
// TESTING
//  1 Reset: rrx_rst_n=0 mid-SCAN -> all outputs 0 immediately; no opeak_valid after release.
//  2 Single peak: WIN_SLOTS=4, thr=1000, lane 5=+5000 at slot 2, others 0
//    -> one opeak_valid, lane 5, mag 5000, index 2, 4 slots after opening.
//  3 Tie/order: lanes 3 and 9 both -7000 in the same slot -> lane 3 reported, mag 7000.
//  4 Saturation: lane 0 = -2^40, thr=0 -> opeak_mag = 2^40-1.
//  5 Overrun: second trig 10 clks after first (SETTLE_CYC=8) -> oovr 1 clk,
//    counter +2, first slot absent from window count.
//  6 Wrap/enable: IDX_W=4, 17 trigs -> index wraps 15->0;
//    erx_en low mid-window -> no report, next crossing reopens the window.

Source files
------------

// File: rtl/rx_peak_scheduler_pkg.sv
// Shared definitions for the receive peak scheduler.
//   rx_state_e : scheduler state encoding (IDLE/SETTLE/SCAN/REPORT)
//   N_CORR_DEF : default number of correlator lanes
//   CORR_W_DEF : default signed width of one correlation result
package rx_pkg;

  localparam int N_CORR_DEF = 16;
  localparam int CORR_W_DEF = 41;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_REPORT = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_peak_scheduler_if.sv
// Bus between the rx correlator bank / time-of-arrival logic and the scheduler.
//   erx_en           : enable, low returns the scheduler to IDLE
//   inew_sample_trig : 1-clk pulse, new sample entered the correlators
//   icorr_results    : flattened signed results, lane k at [k*CORR_W +: CORR_W]
//   ithreshold       : unsigned detection threshold
//   obusy            : scheduler in SETTLE/SCAN/REPORT
//   oovr             : 1-clk pulse, trigger arrived while busy
//   opeak_valid      : 1-clk pulse, peak report valid
//   opeak_lane/mag/index : last reported peak
// The scheduler uses the slave modport, the driving logic the master modport.
interface rx_peak_scheduler_if
  import rx_pkg::*;
#(
  parameter int N_CORR = N_CORR_DEF,
  parameter int CORR_W = CORR_W_DEF,
  parameter int IDX_W  = 16
);
  localparam int LANE_W = $clog2(N_CORR);

  logic                       erx_en;
  logic                       inew_sample_trig;
  logic [N_CORR*CORR_W-1:0]   icorr_results;
  logic [CORR_W-2:0]          ithreshold;
  logic                       obusy;
  logic                       oovr;
  logic                       opeak_valid;
  logic [LANE_W-1:0]          opeak_lane;
  logic [CORR_W-2:0]          opeak_mag;
  logic [IDX_W-1:0]           opeak_index;

  modport slave (
    input  erx_en, inew_sample_trig, icorr_results, ithreshold,
    output obusy, oovr, opeak_valid, opeak_lane, opeak_mag, opeak_index
  );

  modport master (
    output erx_en, inew_sample_trig, icorr_results, ithreshold,
    input  obusy, oovr, opeak_valid, opeak_lane, opeak_mag, opeak_index
  );
endinterface

// File: rtl/rx_peak_scheduler_abs_sat.sv
// Combinational signed -> saturated unsigned magnitude.
//   x   : signed correlation result, CORR_W bits
//   mag : |x| on CORR_W-1 bits; the most negative input saturates to all ones
module rx_abs_sat #(
  parameter int CORR_W = 41
) (
  input  logic signed [CORR_W-1:0] x,
  output logic        [CORR_W-2:0] mag
);

  always_comb begin
    if (!x[CORR_W-1]) begin
      mag = x[CORR_W-2:0];
    end else if (x[CORR_W-2:0] == '0) begin
      // -2^(CORR_W-1) has no positive counterpart in CORR_W-1 bits.
      mag = '1;
    end else begin
      mag = ~x[CORR_W-2:0] + 1'b1;
    end
  end

endmodule

// File: rtl/rx_peak_scheduler.sv
// Receive peak scheduler: after each new sample waits SETTLE_CYC clocks for the
// correlator bank, scans lanes 0..N_CORR-1 one per clock, and tracks the largest
// above-threshold magnitude over a window of WIN_SLOTS completed scans, then
// reports one peak (lane, magnitude, sample index).
//   crx_clk   : clock
//   rrx_rst_n : asynchronous reset, active low
//   bus       : rx_peak_scheduler_if slave modport (see interface header)
module rx_peak_scheduler
  import rx_pkg::*;
#(
  parameter int N_CORR     = N_CORR_DEF,
  parameter int CORR_W     = CORR_W_DEF,
  parameter int SETTLE_CYC = 8,
  parameter int WIN_SLOTS  = 32,
  parameter int IDX_W      = 16
) (
  input  logic               crx_clk,
  input  logic               rrx_rst_n,
  rx_peak_scheduler_if.slave bus
);

  localparam int MAG_W  = CORR_W - 1;
  localparam int LANE_W = $clog2(N_CORR);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int WIN_W  = $clog2(WIN_SLOTS + 1);

  rx_state_e          state;
  logic [SET_W-1:0]   settle_cnt;
  logic [LANE_W-1:0]  lane;
  logic [IDX_W-1:0]   sample_cnt;
  logic [IDX_W-1:0]   slot_idx;
  logic [MAG_W-1:0]   thr;

  // Best of the scan in progress; merged into the window only when the scan
  // completes, so an overrun-aborted scan leaves no trace.
  logic [MAG_W-1:0]   scan_mag;
  logic [LANE_W-1:0]  scan_lane;

  logic               win_open;
  logic [WIN_W-1:0]   win_cnt;
  logic [MAG_W-1:0]   best_mag;
  logic [LANE_W-1:0]  best_lane;
  logic [IDX_W-1:0]   best_idx;

  logic signed [CORR_W-1:0] lane_x;
  logic [MAG_W-1:0]   lane_mag;
  logic [MAG_W-1:0]   fin_mag;
  logic [LANE_W-1:0]  fin_lane;
  logic [MAG_W-1:0]   m_mag;
  logic [LANE_W-1:0]  m_lane;
  logic [IDX_W-1:0]   m_idx;
  logic               win_now;
  logic               last_lane;
  logic               win_done;
  logic               trig_ok;
  logic               busy_st;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, otherwise a path that skips it infers a latch.
  always_comb begin
    lane_x = '0;
    for (int k = 0; k < N_CORR; k++) begin
      if (lane == LANE_W'(k)) lane_x = bus.icorr_results[k*CORR_W +: CORR_W];
    end
  end

  rx_abs_sat #(.CORR_W(CORR_W)) u_abs_sat (
    .x   (lane_x),
    .mag (lane_mag)
  );

  // A candidate must beat the threshold and, strictly, the scan best:
  // ties keep the lower lane. A cleared best of 0 never blocks a candidate
  // because any candidate magnitude is at least 1.
  always_comb begin
    fin_mag  = scan_mag;
    fin_lane = scan_lane;
    if (lane_mag > thr && lane_mag > scan_mag) begin
      fin_mag  = lane_mag;
      fin_lane = lane;
    end
    // Strict compare keeps the earlier slot on equal magnitude.
    m_mag  = best_mag;
    m_lane = best_lane;
    m_idx  = best_idx;
    if (fin_mag > best_mag) begin
      m_mag  = fin_mag;
      m_lane = fin_lane;
      m_idx  = slot_idx;
    end
  end

  assign win_now   = win_open || (fin_mag != '0);
  assign last_lane = (lane == LANE_W'(N_CORR - 1));
  assign win_done  = (win_cnt == WIN_W'(WIN_SLOTS - 1));
  assign trig_ok   = bus.erx_en && bus.inew_sample_trig;
  assign busy_st   = (state == ST_SETTLE) || (state == ST_SCAN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      state           <= ST_IDLE;
      settle_cnt      <= '0;
      lane            <= '0;
      sample_cnt      <= '0;
      slot_idx        <= '0;
      thr             <= '0;
      scan_mag        <= '0;
      scan_lane       <= '0;
      win_open        <= 1'b0;
      win_cnt         <= '0;
      best_mag        <= '0;
      best_lane       <= '0;
      best_idx        <= '0;
      bus.obusy       <= 1'b0;
      bus.oovr        <= 1'b0;
      bus.opeak_valid <= 1'b0;
      bus.opeak_lane  <= '0;
      bus.opeak_mag   <= '0;
      bus.opeak_index <= '0;
    end else begin
      bus.oovr        <= 1'b0;
      bus.opeak_valid <= 1'b0;
      if (!bus.erx_en) begin
        state     <= ST_IDLE;
        bus.obusy <= 1'b0;
        win_open  <= 1'b0;
        win_cnt   <= '0;
        best_mag  <= '0;
        best_lane <= '0;
        best_idx  <= '0;
      end else if (trig_ok) begin
        // Accepted from any state; while SETTLE/SCAN it also aborts the slot.
        bus.oovr   <= busy_st;
        state      <= ST_SETTLE;
        bus.obusy  <= 1'b1;
        settle_cnt <= '0;
        slot_idx   <= sample_cnt;
        sample_cnt <= sample_cnt + IDX_W'(1);
      end else begin
        unique case (state)
          ST_IDLE: ;
          ST_SETTLE: begin
            if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
              state     <= ST_SCAN;
              lane      <= '0;
              scan_mag  <= '0;
              scan_lane <= '0;
              thr       <= bus.ithreshold;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
          ST_SCAN: begin
            scan_mag  <= fin_mag;
            scan_lane <= fin_lane;
            lane      <= lane + LANE_W'(1);
            if (last_lane) begin
              if (win_now && win_done) begin
                state           <= ST_REPORT;
                bus.opeak_valid <= 1'b1;
                bus.opeak_lane  <= m_lane;
                bus.opeak_mag   <= m_mag;
                bus.opeak_index <= m_idx;
                win_open        <= 1'b0;
                win_cnt         <= '0;
                best_mag        <= '0;
                best_lane       <= '0;
                best_idx        <= '0;
              end else begin
                state     <= ST_IDLE;
                bus.obusy <= 1'b0;
                if (win_now) begin
                  win_open  <= 1'b1;
                  win_cnt   <= win_cnt + WIN_W'(1);
                  best_mag  <= m_mag;
                  best_lane <= m_lane;
                  best_idx  <= m_idx;
                end
              end
            end
          end
          ST_REPORT: begin
            state     <= ST_IDLE;
            bus.obusy <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
